// File: rtl/mem_arbiter.sv
// Two-client arbiter for the single-port 16x8 scratch memory. Optional MEM_ARB_PREEMPT_EN enables MAX_BURST preemption.
// Latency: grant 1 cycle after request from IDLE, 0-cycle handover; read data valid 1 cycle after an accepted read.
// Backpressure: a waiting client holds req until granted; an owner keeps the port until req drops (or until burst preemption).
module mem_arbiter #(
    parameter int AW        = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
`ifdef MEM_ARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    state_t     state_q, state_d;
    logic       last_q, last_d;      // previous owner, decides IDLE tie-break
    logic [3:0] cnt_q, cnt_d;        // accesses made in the current ownership
    logic       rvalid0_q, rvalid1_q;

    logic       acc0, acc1;
    logic [3:0] cnt_inc;
    logic       burst_done;

    assign acc0 = (state_q == OWN0) && req0;
    assign acc1 = (state_q == OWN1) && req1;

    // Saturate so a late-arriving contender still preempts on the next access.
    assign cnt_inc    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    assign burst_done = PREEMPT && (cnt_inc >= BURST_LIM);

    // Ownership, tie-break and burst-count next state.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1)
                    state_d = last_q ? OWN0 : OWN1;
                else if (req0)
                    state_d = OWN0;
                else if (req1)
                    state_d = OWN1;
            end
            OWN0: begin
                if (!req0) begin
                    state_d = req1 ? OWN1 : IDLE;
                    last_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (burst_done && req1) begin
                        state_d = OWN1;
                        last_d  = 1'b0;
                    end
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_d = req0 ? OWN0 : IDLE;
                    last_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    if (burst_done && req0) begin
                        state_d = OWN0;
                        last_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q)
            cnt_d = 4'd0;
    end

    // Arbitration state registers; last resets to 1 so client 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read-response flags track the memory's one-cycle read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= acc0 && !we0;
            rvalid1_q <= acc1 && !we1;
        end
    end

    // Memory port steered combinationally from the owner; idle port drives zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (acc0) begin
            mem_en    = 1'b1;
            mem_rw    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (acc1) begin
            mem_en    = 1'b1;
            mem_rw    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    assign gnt0    = (state_q == OWN0);
    assign gnt1    = (state_q == OWN1);
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = mem_rdata;
    assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scripted clients, a 16x8 memory model and a read scoreboard.
// Expected ownership per cycle is given as a table; reads push expected data on acceptance.
// Optional MEM_ARB_PREEMPT_EN selects the preemptive contention table.
module tb_mem_arbiter;

    typedef struct {
        logic       we;
        logic [3:0] a;
        logic [7:0] d;
    } op_t;

    typedef struct {
        int         c;
        logic [7:0] d;
        int         cyc;
    } sb_t;

    logic       clk;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       mem_en, mem_rw;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    sb_t        sb[$];
    op_t        q0[$], q1[$];
    int         start0, start1;
    int         exp_q[$];
    int         cyc;
    int         n_vec, n_err;

    mem_arbiter #(.AW(4), .DW(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scratch memory model: registered read, one-cycle latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rw) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Read responses are matched in order against the scoreboard.
    always @(negedge clk) begin : mon
        sb_t e;
        if (reset) chk("gnt_excl", {31'b0, gnt0 & gnt1}, 32'd0);
        if (rvalid0 || rvalid1) begin
            if (sb.size() == 0) begin
                chk("rv_unexp", {30'b0, rvalid1, rvalid0}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rv_client", {30'b0, rvalid1, rvalid0}, (e.c == 0) ? 32'd1 : 32'd2);
                chk("rv_data", rvalid1 ? rdata1 : rdata0, e.d);
                chk("rv_cycle", cyc, e.cyc);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("rv_missing", {30'b0, rvalid1, rvalid0}, (e.c == 0) ? 32'd1 : 32'd2);
        end
    end

    task automatic add_op(input int c, input logic we, input logic [3:0] a, input logic [7:0] d);
        op_t o;
        o.we = we; o.a = a; o.d = d;
        if (c == 0) q0.push_back(o);
        else        q1.push_back(o);
    endtask

    task automatic clear_clients();
        q0.delete();
        q1.delete();
        start0 = 0;
        start1 = 0;
    endtask

    // Runs one cycle per exp_q entry (0 none, 1 client 0, 2 client 1 owns).
    // At cycle rst_at, reset is asserted mid-cycle and the run stops.
    task automatic run(input int rst_at);
        int  i0, i1;
        bit  r0, r1, a0, a1;
        op_t o0, o1, op;
        i0 = 0; i1 = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            r0 = (k >= start0) && (i0 < q0.size());
            r1 = (k >= start1) && (i1 < q1.size());
            o0 = '{default: 0};
            o1 = '{default: 0};
            if (r0) o0 = q0[i0];
            if (r1) o1 = q1[i1];
            req0 = r0; we0 = o0.we; addr0 = o0.a; wdata0 = o0.d;
            req1 = r1; we1 = o1.we; addr1 = o1.a; wdata1 = o1.d;
            @(negedge clk);
            chk("gnt0", {31'b0, gnt0}, (exp_q[k] == 1) ? 32'd1 : 32'd0);
            chk("gnt1", {31'b0, gnt1}, (exp_q[k] == 2) ? 32'd1 : 32'd0);
            a0 = r0 && (exp_q[k] == 1);
            a1 = r1 && (exp_q[k] == 2);
            chk("mem_en", {31'b0, mem_en}, {31'b0, a0 | a1});
            if (a0 || a1) begin
                op = a0 ? o0 : o1;
                chk("mem_rw", {31'b0, mem_rw}, {31'b0, op.we});
                chk("mem_addr", {28'b0, mem_addr}, {28'b0, op.a});
                chk("mem_wdata", {24'b0, mem_wdata}, {24'b0, op.d});
                if (op.we) ref_mem[op.a] = op.d;
                else       sb.push_back('{a1 ? 1 : 0, ref_mem[op.a], cyc + 1});
            end
            if (k == rst_at) begin
                #2 reset = 1'b0;
                #1;
                chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
                chk("rst_gnt1", {31'b0, gnt1}, 32'd0);
                chk("rst_rvalid0", {31'b0, rvalid0}, 32'd0);
                chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
                sb.delete();
                return;
            end
            @(posedge clk); #1;
            if (a0) i0++;
            if (a1) i1++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        n_vec = 0; n_err = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt0", {31'b0, gnt0}, 32'd0);
        chk("reset_gnt1", {31'b0, gnt1}, 32'd0);
        chk("reset_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
        chk("reset_mem_en", {31'b0, mem_en}, 32'd0);
        reset = 1'b1;

        // Client 0 alone writes 0x11..0x14 to addresses 0..3, then releases.
        clear_clients();
        for (int i = 0; i < 4; i++) add_op(0, 1'b1, 4'(i), 8'(8'h11 + i));
        exp_q = '{0, 1, 1, 1, 1, 1, 0};
        run(-1);

        // Client 1 reads back address 3.
        clear_clients();
        add_op(1, 1'b0, 4'd3, 8'h00);
        exp_q = '{0, 2, 2, 0, 0};
        run(-1);

        // Both request together after a fresh reset; client 0 wants 10 accesses.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        clear_clients();
        for (int i = 0; i < 10; i++) add_op(0, 1'b1, 4'(4 + i), 8'(8'h40 + i));
        for (int i = 0; i < 6; i++)  add_op(1, 1'b0, 4'(i), 8'h00);
`ifdef MEM_ARB_PREEMPT_EN
        exp_q = '{0, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 2, 2, 2, 1, 1, 1, 0, 0};
`else
        exp_q = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 0, 0};
`endif
        run(-1);

        // Owner drops req as the other raises it: direct handover, no IDLE cycle.
        clear_clients();
        for (int i = 0; i < 3; i++) add_op(0, 1'b1, 4'(14 + (i % 2)), 8'(8'hA0 + i));
        add_op(1, 1'b0, 4'd14, 8'h00);
        add_op(1, 1'b0, 4'd15, 8'h00);
        start1 = 4;
        exp_q = '{0, 1, 1, 1, 1, 2, 2, 2, 0, 0};
        run(-1);

        // Client 0 owns last, then a read burst is cut by reset.
        clear_clients();
        add_op(0, 1'b1, 4'd6, 8'h5A);
        exp_q = '{0, 1, 1, 0};
        run(-1);
        clear_clients();
        for (int i = 0; i < 6; i++) add_op(0, 1'b0, 4'(i), 8'h00);
        exp_q = '{0, 1, 1, 1};
        run(3);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        chk("rst_hold_mem_en", {31'b0, mem_en}, 32'd0);
        reset = 1'b1;

        // After release a tie goes to client 0 again.
        clear_clients();
        add_op(0, 1'b0, 4'd1, 8'h00);
        add_op(1, 1'b0, 4'd2, 8'h00);
        exp_q = '{0, 1, 1, 2, 2, 0, 0};
        run(-1);

        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
